// File: rtl/ecg_gate_ctrl.sv
// ECG-triggered imaging gate controller: hysteresis peak detector, beat interval
// averaging over 2^NAVG_LOG2 beats, lock/timeout FSM and a percentage-window gate.
module ecg_gate_ctrl #(
  parameter int unsigned DW        = 12,
  parameter int unsigned CW        = 32,
  parameter int unsigned NAVG_LOG2 = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          sample_valid,
  input  logic [DW-1:0] sample,
  input  logic [DW-1:0] thr_hi,
  input  logic [DW-1:0] thr_lo,
  input  logic [CW-1:0] refractory,
  input  logic [CW-1:0] timeout,
  input  logic [6:0]    delay_pct,
  input  logic [6:0]    end_pct,
  input  logic [1:0]    mode,
  output logic          gate,
  output logic          beat,
  output logic          missed,
  output logic [CW-1:0] avg_period,
  output logic          locked
);

  localparam int unsigned DEPTH = 1 << NAVG_LOG2;
  localparam int unsigned SW    = CW + NAVG_LOG2;
  localparam int unsigned PW    = CW + 7;
  localparam int unsigned FW    = NAVG_LOG2 + 1;
  localparam logic [FW-1:0] FILL_FULL = FW'(DEPTH);
  localparam logic [FW-1:0] FILL_LAST = FW'(DEPTH - 1);

  typedef enum logic { DET_ARMED, DET_PEAK } det_e;
  typedef enum logic [1:0] { ST_IDLE, ST_ACQUIRE, ST_TRACK } st_e;

  det_e det_q, det_d;
  st_e  st_q, st_d;

  logic [CW-1:0]        ivl_q, ivl_d, ivl_inc;
  logic [SW-1:0]        sum_q, sum_d;
  logic [FW-1:0]        fill_q, fill_d;
  logic [NAVG_LOG2-1:0] wr_q, wr_d;
  logic [CW-1:0]        avg_q, avg_d;
  logic [CW-1:0]        buf_q [DEPTH];
  logic [CW-1:0]        oldest;
  logic                 gate_q, gate_d, beat_q, beat_d, missed_q, missed_d;
  logic                 cand, accept, tmo, full, wr_en;
  logic [PW-1:0]        prod_ivl, prod_lo, prod_hi;

  always_comb begin
    det_d = det_q;
    cand  = 1'b0;
    if (sample_valid) begin
      case (det_q)
        DET_ARMED: if (sample >= thr_hi) det_d = DET_PEAK;
        DET_PEAK: begin
          if (sample <= thr_lo) begin
            det_d = DET_ARMED;
            cand  = 1'b1;
          end
        end
        default: det_d = DET_ARMED;
      endcase
    end
  end

  always_comb begin
    ivl_inc  = (ivl_q == '1) ? ivl_q : ivl_q + CW'(1);
    accept   = cand && (ivl_q >= refractory);
    tmo      = (st_q != ST_IDLE) && (ivl_q == timeout);
    full     = (fill_q == FILL_FULL);
    oldest   = full ? buf_q[wr_q] : '0;
    st_d     = st_q;
    ivl_d    = ivl_inc;
    sum_d    = sum_q;
    fill_d   = fill_q;
    wr_d     = wr_q;
    avg_d    = avg_q;
    beat_d   = 1'b0;
    missed_d = tmo;
    wr_en    = 1'b0;
    if (tmo) begin
      // a beat colliding with timeout restarts timing silently from IDLE
      st_d   = accept ? ST_ACQUIRE : ST_IDLE;
      ivl_d  = accept ? '0 : ivl_inc;
      sum_d  = '0;
      fill_d = '0;
      wr_d   = '0;
      avg_d  = '0;
    end else begin
      if (st_q == ST_TRACK) avg_d = CW'(sum_q >> NAVG_LOG2);
      if (accept) begin
        beat_d = 1'b1;
        ivl_d  = '0;
        if (st_q == ST_IDLE) begin
          st_d = ST_ACQUIRE;
        end else begin
          // stored interval counts the beat cycle itself (counter's next value)
          wr_en = 1'b1;
          wr_d  = wr_q + NAVG_LOG2'(1);
          sum_d = sum_q + SW'(ivl_inc) - SW'(oldest);
          if (!full) begin
            fill_d = fill_q + FW'(1);
            if (fill_q == FILL_LAST) st_d = ST_TRACK;
          end
        end
      end
    end
  end

  always_comb begin
    prod_ivl = PW'(ivl_q) * PW'(7'd100);
    prod_lo  = PW'(avg_q) * PW'(delay_pct);
    prod_hi  = PW'(avg_q) * PW'(end_pct);
    case (mode)
      2'b01:   gate_d = 1'b1;
      2'b10:   gate_d = (st_q == ST_TRACK) && (prod_ivl > prod_lo) && (prod_ivl < prod_hi);
      default: gate_d = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      det_q    <= DET_ARMED;
      st_q     <= ST_IDLE;
      ivl_q    <= '0;
      sum_q    <= '0;
      fill_q   <= '0;
      wr_q     <= '0;
      avg_q    <= '0;
      gate_q   <= 1'b0;
      beat_q   <= 1'b0;
      missed_q <= 1'b0;
    end else begin
      det_q    <= det_d;
      st_q     <= st_d;
      ivl_q    <= ivl_d;
      sum_q    <= sum_d;
      fill_q   <= fill_d;
      wr_q     <= wr_d;
      avg_q    <= avg_d;
      gate_q   <= gate_d;
      beat_q   <= beat_d;
      missed_q <= missed_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) buf_q[i] <= '0;
    end else if (wr_en) begin
      buf_q[wr_q] <= ivl_inc;
    end
  end

  assign gate       = gate_q;
  assign beat       = beat_q;
  assign missed     = missed_q;
  assign avg_period = avg_q;
  assign locked     = (st_q == ST_TRACK);

endmodule

// File: tb/tb_ecg_gate_ctrl.sv
// Directed bench for ecg_gate_ctrl: lock acquisition, gate window, refractory,
// timeout, timeout/beat collision and asynchronous reset.
module tb_ecg_gate_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        sample_valid;
  logic [11:0] sample, thr_hi, thr_lo;
  logic [31:0] refractory, timeout;
  logic [6:0]  delay_pct, end_pct;
  logic [1:0]  mode;
  logic        gate, beat, missed, locked;
  logic [31:0] avg_period;

  int checks = 0;
  int passed = 0;
  int pos = 0;

  ecg_gate_ctrl #(.DW(12), .CW(32), .NAVG_LOG2(3)) dut (
    .clk(clk), .rst(rst), .sample_valid(sample_valid), .sample(sample),
    .thr_hi(thr_hi), .thr_lo(thr_lo), .refractory(refractory), .timeout(timeout),
    .delay_pct(delay_pct), .end_pct(end_pct), .mode(mode),
    .gate(gate), .beat(beat), .missed(missed), .avg_period(avg_period), .locked(locked)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(negedge clk);
    pos++;
  endtask

  task automatic go_to(input int p);
    while (pos < p) tick();
  endtask

  // Peak whose falling edge makes the beat pulse visible at pos == p; pos restarts at 0.
  task automatic peak_beat_at(input int p);
    go_to(p - 2);
    sample = 12'd100;
    tick();
    sample = 12'd0;
    tick();
    pos = 0;
  endtask

  task automatic test_reset();
    rst = 1'b1; sample_valid = 1'b1; sample = '0;
    thr_hi = 12'd90; thr_lo = 12'd60; refractory = 32'd300; timeout = 32'd3000;
    delay_pct = 7'd20; end_pct = 7'd80; mode = 2'b01;
    repeat (3) @(negedge clk);
    checks++; if (gate !== 1'b0) $display("FAIL reset_gate: got %0b expected 0", gate); else passed++;
    checks++; if (beat !== 1'b0) $display("FAIL reset_beat: got %0b expected 0", beat); else passed++;
    checks++; if (missed !== 1'b0) $display("FAIL reset_missed: got %0b expected 0", missed); else passed++;
    checks++; if (locked !== 1'b0) $display("FAIL reset_locked: got %0b expected 0", locked); else passed++;
    checks++; if (avg_period !== 32'd0) $display("FAIL reset_avg: got %0d expected 0", avg_period); else passed++;
    mode = 2'b10;
    rst = 1'b0;
    pos = 0;
  endtask

  task automatic test_acquire();
    for (int i = 1; i <= 9; i++) begin
      peak_beat_at(1000);
      checks++; if (beat !== 1'b1) $display("FAIL acq_beat%0d: got %0b expected 1", i, beat); else passed++;
      checks++;
      if (locked !== (i == 9)) $display("FAIL acq_locked%0d: got %0b expected %0b", i, locked, (i == 9));
      else passed++;
    end
    tick();
    checks++; if (avg_period !== 32'd1000) $display("FAIL acq_avg: got %0d expected 1000", avg_period); else passed++;
  endtask

  task automatic test_gate_window();
    logic exp_g;
    for (int j = 2; j <= 1000; j++) begin
      if (j == 999) sample = 12'd100;
      if (j == 1000) sample = 12'd0;
      tick();
      exp_g = ((j - 1) > 200) && ((j - 1) < 800);
      checks++; if (gate !== exp_g) $display("FAIL gate_win@%0d: got %0b expected %0b", j, gate, exp_g); else passed++;
    end
    pos = 0;
    checks++; if (beat !== 1'b1) $display("FAIL gate_win_beat: got %0b expected 1", beat); else passed++;
  endtask

  task automatic test_refractory();
    go_to(148);
    sample = 12'd100;
    tick();
    sample = 12'd0;
    tick();
    checks++; if (beat !== 1'b0) $display("FAIL refr_nobeat: got %0b expected 0", beat); else passed++;
    peak_beat_at(1000);
    checks++; if (beat !== 1'b1) $display("FAIL refr_beat: got %0b expected 1", beat); else passed++;
    tick();
    checks++; if (avg_period !== 32'd1000) $display("FAIL refr_avg: got %0d expected 1000", avg_period); else passed++;
  endtask

  task automatic test_modes();
    delay_pct = 7'd80; end_pct = 7'd20;
    go_to(500);
    checks++; if (gate !== 1'b0) $display("FAIL pct_inverted: got %0b expected 0", gate); else passed++;
    delay_pct = 7'd20; end_pct = 7'd80;
    tick();
    checks++; if (gate !== 1'b1) $display("FAIL pct_restored: got %0b expected 1", gate); else passed++;
    mode = 2'b00; tick();
    checks++; if (gate !== 1'b0) $display("FAIL mode00: got %0b expected 0", gate); else passed++;
    mode = 2'b11; tick();
    checks++; if (gate !== 1'b0) $display("FAIL mode11: got %0b expected 0", gate); else passed++;
    mode = 2'b10; tick();
    checks++; if (gate !== 1'b1) $display("FAIL mode10_in: got %0b expected 1", gate); else passed++;
    go_to(900);
    checks++; if (gate !== 1'b0) $display("FAIL mode10_out: got %0b expected 0", gate); else passed++;
    mode = 2'b01; tick();
    checks++; if (gate !== 1'b1) $display("FAIL mode01_out: got %0b expected 1", gate); else passed++;
    mode = 2'b10; tick();
    checks++; if (gate !== 1'b0) $display("FAIL mode10_back: got %0b expected 0", gate); else passed++;
    peak_beat_at(1000);
    checks++; if (beat !== 1'b1) $display("FAIL modes_beat: got %0b expected 1", beat); else passed++;
  endtask

  task automatic test_timeout();
    go_to(3000);
    checks++; if (missed !== 1'b0) $display("FAIL tmo_early: got %0b expected 0", missed); else passed++;
    tick();
    checks++; if (missed !== 1'b1) $display("FAIL tmo_missed: got %0b expected 1", missed); else passed++;
    checks++; if (locked !== 1'b0) $display("FAIL tmo_locked: got %0b expected 0", locked); else passed++;
    checks++; if (avg_period !== 32'd0) $display("FAIL tmo_avg: got %0d expected 0", avg_period); else passed++;
    tick();
    checks++; if (missed !== 1'b0) $display("FAIL tmo_pulse: got %0b expected 0", missed); else passed++;
    checks++; if (gate !== 1'b0) $display("FAIL tmo_gate: got %0b expected 0", gate); else passed++;
    peak_beat_at(3500);
    checks++; if (beat !== 1'b1) $display("FAIL tmo_first_beat: got %0b expected 1", beat); else passed++;
    checks++; if (locked !== 1'b0) $display("FAIL tmo_relock: got %0b expected 0", locked); else passed++;
  endtask

  task automatic test_collision();
    timeout = 32'd999;
    peak_beat_at(1000);
    checks++; if (beat !== 1'b0) $display("FAIL coll_beat: got %0b expected 0", beat); else passed++;
    checks++; if (missed !== 1'b1) $display("FAIL coll_missed: got %0b expected 1", missed); else passed++;
    timeout = 32'd3000;
    for (int i = 1; i <= 8; i++) begin
      peak_beat_at(1000);
      checks++; if (beat !== 1'b1) $display("FAIL coll_beat%0d: got %0b expected 1", i, beat); else passed++;
      checks++;
      if (locked !== (i == 8)) $display("FAIL coll_locked%0d: got %0b expected %0b", i, locked, (i == 8));
      else passed++;
    end
    tick();
    checks++; if (avg_period !== 32'd1000) $display("FAIL coll_avg: got %0d expected 1000", avg_period); else passed++;
  endtask

  task automatic test_reset_mid_track();
    mode = 2'b01;
    tick();
    checks++; if (gate !== 1'b1) $display("FAIL rst_pre_gate: got %0b expected 1", gate); else passed++;
    #2 rst = 1'b1;
    #1;
    checks++; if (gate !== 1'b0) $display("FAIL rst_async_gate: got %0b expected 0", gate); else passed++;
    checks++; if (locked !== 1'b0) $display("FAIL rst_async_locked: got %0b expected 0", locked); else passed++;
    checks++; if (avg_period !== 32'd0) $display("FAIL rst_async_avg: got %0d expected 0", avg_period); else passed++;
    checks++; if (beat !== 1'b0 || missed !== 1'b0)
      $display("FAIL rst_async_pulses: got %0b%0b expected 00", beat, missed);
    else passed++;
    @(negedge clk);
    rst = 1'b0;
    pos = 0;
    tick();
    checks++; if (gate !== 1'b1) $display("FAIL unlocked_mode01: got %0b expected 1", gate); else passed++;
    mode = 2'b00;
    tick();
    checks++; if (gate !== 1'b0) $display("FAIL unlocked_mode00: got %0b expected 0", gate); else passed++;
    mode = 2'b10;
    for (int i = 1; i <= 9; i++) begin
      peak_beat_at(1000);
      checks++;
      if (locked !== (i == 9)) $display("FAIL relock%0d: got %0b expected %0b", i, locked, (i == 9));
      else passed++;
    end
    tick();
    checks++; if (avg_period !== 32'd1000) $display("FAIL relock_avg: got %0d expected 1000", avg_period); else passed++;
  endtask

  initial begin
    test_reset();
    test_acquire();
    test_gate_window();
    test_refractory();
    test_modes();
    test_timeout();
    test_collision();
    test_reset_mid_track();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/ecg_gate_ctrl.md
ECG_GATE_CTRL -- requirements
Module: ecg_gate_ctrl

Interface
REQ-001 SHALL have parameter DW, default 12: ADC sample width in bits.
REQ-002 SHALL have parameter CW, default 32: interval counter and period width in bits.
REQ-003 SHALL have parameter NAVG_LOG2, default 3: averaging window is 2^NAVG_LOG2 beat intervals.
REQ-004 SHALL have port clk, input, 1: single system clock; all logic is on its rising edge.
REQ-005 SHALL have port rst, input, 1: reset; asynchronous and active-high.
REQ-006 SHALL have port sample_valid, input, 1: sample qualifier.
REQ-007 SHALL have port sample, input, DW: unsigned ECG sample.
REQ-008 SHALL have ports thr_hi and thr_lo, input, DW each: hysteresis thresholds; thr_lo <= thr_hi is required of the user.
REQ-009 SHALL have port refractory, input, CW: minimum accepted beat interval, in clk cycles.
REQ-010 SHALL have port timeout, input, CW: maximum beat interval before loss of lock.
REQ-011 SHALL have ports delay_pct and end_pct, input, 7 each: gate window bounds, 0-100 % of the average period.
REQ-012 SHALL have port mode, input, 2: 00 forces gate 0, 01 forces gate 1, 10 selects gated operation, 11 forces gate 0.
REQ-013 SHALL have port gate, output, 1: imaging gate.
REQ-014 SHALL have port beat, output, 1: one-cycle pulse on each accepted beat.
REQ-015 SHALL have port missed, output, 1: one-cycle pulse on timeout.
REQ-016 SHALL have ports avg_period, output, CW, and locked, output, 1.

Function
REQ-017 Peak detector SHALL have two states, ARMED and PEAK, updated only when sample_valid=1.
- ARMED -> PEAK when sample >= thr_hi.
- PEAK -> ARMED when sample <= thr_lo; this transition is a candidate beat.
REQ-018 Interval counter ivl SHALL increment by 1 every cycle and saturate at 2^CW-1.
REQ-019 A candidate beat with ivl < refractory SHALL be discarded: no beat pulse, ivl not cleared.
REQ-020 An accepted beat SHALL pulse beat in the cycle after the candidate and SHALL clear ivl to 0 in that same cycle.
REQ-021 Control FSM SHALL have three states:
- IDLE: no beat timed yet.
- ACQUIRE: filling the interval buffer.
- TRACK: locked.
REQ-022 IDLE: the first accepted beat SHALL only start timing (no interval stored), then go to ACQUIRE.
REQ-023 ACQUIRE/TRACK: each accepted beat SHALL write ivl into a circular buffer of depth 2^NAVG_LOG2 and update the running sum as sum + ivl - oldest. The sum is CW+NAVG_LOG2 bits; oldest reads 0 while the buffer is not yet full.
REQ-024 ACQUIRE -> TRACK when the buffer fill count reaches 2^NAVG_LOG2.
REQ-025 avg_period SHALL equal sum >> NAVG_LOG2, registered, updated only in TRACK. It is valid one cycle after the beat pulse.
REQ-026 locked SHALL be 1 exactly in TRACK.
REQ-027 In ACQUIRE or TRACK, ivl == timeout SHALL pulse missed for one cycle and go to IDLE, clearing the fill count, sum and avg_period.
REQ-028 Timeout and a candidate beat in the same cycle: timeout SHALL win, and the beat SHALL be taken as the IDLE first beat.
REQ-029 In mode 10, gate SHALL be 1 iff locked and ivl*100 > avg_period*delay_pct and ivl*100 < avg_period*end_pct. Products are CW+7 bits with no truncation.
REQ-030 gate SHALL be registered: one cycle of latency from ivl/state to gate, in every mode.
REQ-031 delay_pct >= end_pct SHALL yield gate 0 in mode 10.
REQ-032 Changes to mode, thresholds and percentages SHALL take effect on the next cycle with no FSM reset.

Reset
REQ-033 While rst=1: detector ARMED, FSM IDLE, ivl, sum, fill count, buffer and avg_period 0; gate, beat, missed and locked 0.
REQ-034 Deassertion of rst SHALL resume operation on the first following clk edge; rst mid-ACQUIRE or mid-TRACK SHALL discard all history.

Verification
REQ-035 Defaults, thr_hi=90, thr_lo=60, peaks every 1000 cycles: locked rises after the 9th accepted beat; avg_period=1000.
REQ-036 Locked at period 1000, delay_pct=20, end_pct=80, mode=10: gate is 1 for ivl in 201..799, delayed one cycle; 0 otherwise.
REQ-037 Extra peak 150 cycles after a beat with refractory=300: no beat pulse; avg_period stays 1000.
REQ-038 Peaks stop with timeout=3000: missed pulses at ivl=3000; locked=0, gate=0, avg_period=0; the next peak returns the FSM to ACQUIRE.
REQ-039 Peak falling edge on the same cycle as ivl==timeout: missed pulses, no beat pulse, FSM ends in ACQUIRE with ivl=0.
REQ-040 rst asserted mid-TRACK: all outputs are 0 asynchronously; after release, 9 beats are needed to relock. mode=01 gives gate=1 and mode=00 gives gate=0 regardless of lock.
